data_memory_sync: RTL and testbench
===================================

// Module: data_memory_sync
// PURPOSE
//  Clocked, parametrised data memory for the single-cycle/pipelined CPU datapath (MEM stage).
//  Byte-addressed, supports byte/half/word stores via lane enables and sign/zero-extended loads.
//  Registered read (1-cycle latency) with valid flag, misalignment error, and a hardware clear FSM after reset.
// PARAMETERS
//  DEPTH          16   number of 32-bit words; power of two, >= 2
//  ADDR_W         32   width of byte address input (ALU result)
//  CLEAR_ON_RESET 1    1: zero all words after reset via CLEAR FSM; 0: skip CLEAR, contents undefined after reset
// PORTS
//  clk            in   1       rising-edge clock, sole clock
//  rst            in   1       synchronous reset, active-high
//  mem_read       in   1       load request, sampled at clk edge
//  mem_write      in   1       store request, sampled at clk edge
//  addr           in   ADDR_W  byte address; word index = addr[IDX_W+1:2], IDX_W = $clog2(DEPTH)
//  wdata          in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  size           in   2       00 byte, 01 half, 10 word, 11 reserved (treated as error)
//  load_unsigned  in   1       1: zero-extend byte/half loads; 0: sign-extend
//  ready          out  1       1 when requests are accepted (IDLE state)
//  rdata_valid    out  1       1-cycle pulse, rdata holds load result
//  rdata          out  32      load result; 0 when rdata_valid=0
//  access_err     out  1       1-cycle pulse: misaligned, reserved size, or read+write together
//  busy           out  1       1 while CLEAR FSM runs
// BEHAVIOUR
//  - Reset: synchronous, active-high. While rst=1: rdata=0, rdata_valid=0, access_err=0, ready=0.
//    busy=1 if CLEAR_ON_RESET, else busy=0. Clear counter returns to 0.
//  - FSM states: CLEAR, IDLE.
//    rst -> CLEAR (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0).
//    CLEAR: writes mem[clr_idx]=0 each cycle, clr_idx++; after index DEPTH-1 -> IDLE. Takes exactly DEPTH cycles.
//    Requests arriving in CLEAR are dropped: no write, no rdata_valid, no access_err.
//  - ready = (state==IDLE) && !rst; busy = (state==CLEAR).
//  - Store, IDLE, mem_write=1, mem_read=0, legal: lanes written at the clk edge.
//    byte: lane addr[1:0] <= wdata[7:0]. half: lanes {addr[1],0}+1:0 <= wdata[15:0]. word: all lanes.
//    Unselected lanes unchanged. No rdata_valid.
//  - Load, IDLE, mem_read=1, mem_write=0, legal: word latched at the edge.
//    Next cycle rdata_valid=1; rdata = selected lane(s), extended per load_unsigned.
//  - Alignment: half needs addr[0]=0, word needs addr[1:0]=0.
//    Violation or size=11: no memory change; access_err=1 next cycle.
//    For loads, rdata_valid=1 with rdata=0 so the pipeline never stalls waiting.
//  - mem_read & mem_write in the same cycle: illegal; nothing written; access_err=1, rdata_valid=0 next cycle.
//  - Back-to-back: store to A at cycle n, load from A at cycle n+1 returns the new data (no bypass needed).
//    Loads may issue every cycle, each result 1 cycle later.
//  - Address wrap: bits above IDX_W+1 ignored, so the index wraps modulo DEPTH. No out-of-range error.
//  - rst asserted mid-CLEAR or mid-access: pending rdata_valid/access_err cancelled; CLEAR restarts at index 0.
//  - Outputs rdata/rdata_valid/access_err are registered; no combinational path from inputs to outputs
//    except ready (from state, rst).
// STRUCTURE
//  - mem_pkg: SIZE_BYTE/HALF/WORD/RSVD encodings, state enum {ST_CLEAR, ST_IDLE}, shared with decoder/control unit.
//  - One sub-module, load_align_ext (combinational): word + addr[1:0] + size + load_unsigned -> 32-bit extended result.
//    Instantiated on the registered read path. Store lane-enable generation stays inline.
// TESTING
//  1. Reset, CLEAR_ON_RESET=1, DEPTH=16: rst 2 cycles, release -> busy=1 exactly 16 cycles, then ready=1.
//     Loads of all words return 0.
//  2. Word store 0xDEADBEEF @0x8, load word @0x8 next cycle -> rdata_valid pulse 1 cycle later, rdata=0xDEADBEEF.
//  3. Byte store 0x80 @0x9 over 0x00000000 -> word @0x8 = 0x00008000.
//     lb @0x9 -> 0xFFFFFF80; lbu @0x9 -> 0x00000080.
//  4. Half store @0x3 or word load @0x6 -> access_err pulse, memory unchanged, load gives rdata_valid=1, rdata=0.
//     mem_read=mem_write=1 -> access_err=1, no write.
//  5. Wrap: word store 0x11 @0x40 with DEPTH=16 -> load @0x0 returns 0x11.
//  6. Reset mid-CLEAR at cycle 5: CLEAR restarts, busy lasts 16 more cycles.
//     Request issued during busy -> ignored, no rdata_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, FSM states,
// and the legality rule used by both the memory and the decoder.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } mem_state_e;

    // True when the access size is defined and the byte offset is naturally aligned.
    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = (lo[0] == 1'b0);
            SIZE_WORD: ok = (lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed byte/half/word out of a memory word and sign- or
// zero-extends it to 32 bits.
module load_align_ext
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lo,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = 32'h0;
        case (size)
            SIZE_BYTE: result = {{24{byte_sel[7] & ~load_unsigned}}, byte_sel};
            SIZE_HALF: result = {{16{half_sel[15] & ~load_unsigned}}, half_sel};
            SIZE_WORD: result = word;
            default:   result = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_sync.sv
// Byte-addressed MEM-stage data memory: lane-enabled stores, registered
// sign/zero-extended loads, access error pulses and a zeroing FSM after reset.
module data_memory_sync
    import mem_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    output logic              ready,
    output logic              rdata_valid,
    output logic [31:0]       rdata,
    output logic              access_err,
    output logic              busy
);

    localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [31:0] mem_q [DEPTH];

    mem_state_e  state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

    logic        rd_vld_q,  rd_vld_d;
    logic        rd_ok_q,   rd_ok_d;
    logic        err_q,     err_d;
    logic [31:0] rd_word_q, rd_word_d;
    logic [1:0]  rd_lo_q,   rd_lo_d;
    logic [1:0]  rd_size_q, rd_size_d;
    logic        rd_uns_q,  rd_uns_d;

    logic [IDX_W-1:0] idx;
    logic [1:0]       lo;
    logic             legal;
    logic             accept;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    logic [31:0] ext_word;

    // Upper address bits are deliberately ignored so the index wraps.
    logic unused_addr;
    assign unused_addr = ^addr[ADDR_W-1:IDX_W+2];

    assign idx    = addr[IDX_W+1:2];
    assign lo     = addr[1:0];
    assign legal  = access_legal(size, lo);
    assign accept = (state_q == ST_IDLE) && !rst;

    // ------------------------------------------------------------------
    // Control FSM: CLEAR walks every index once, then parks in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + IDX_W'(1);
            if (clr_idx_q == LAST_IDX) begin
                state_d   = ST_IDLE;
                clr_idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Write port: shared by the clear sweep and legal stores.
    // ------------------------------------------------------------------
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_be   = 4'b0000;
        wr_data = 32'h0;
        if (!rst && state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx_q;
            wr_be   = 4'b1111;
            wr_data = 32'h0;
        end else if (accept && mem_write && !mem_read && legal) begin
            wr_en = 1'b1;
            // Data is replicated across lanes so the enables alone pick placement.
            case (size)
                SIZE_BYTE: begin
                    wr_be   = 4'b0001 << lo;
                    wr_data = {4{wdata[7:0]}};
                end
                SIZE_HALF: begin
                    wr_be   = lo[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{wdata[15:0]}};
                end
                default: begin
                    wr_be   = 4'b1111;
                    wr_data = wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read / error capture. The raw word is registered; alignment and
    // extension happen after the register so outputs stay flop-driven.
    // ------------------------------------------------------------------
    always_comb begin
        rd_vld_d  = 1'b0;
        rd_ok_d   = 1'b0;
        err_d     = 1'b0;
        rd_word_d = rd_word_q;
        rd_lo_d   = rd_lo_q;
        rd_size_d = rd_size_q;
        rd_uns_d  = rd_uns_q;
        if (accept) begin
            if (mem_read && mem_write) begin
                err_d = 1'b1;
            end else if (mem_read) begin
                rd_vld_d  = 1'b1;
                rd_ok_d   = legal;
                err_d     = !legal;
                rd_word_d = mem_q[idx];
                rd_lo_d   = lo;
                rd_size_d = size;
                rd_uns_d  = load_unsigned;
            end else if (mem_write) begin
                err_d = !legal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_ok_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_word_q <= 32'h0;
            rd_lo_q   <= 2'b00;
            rd_size_q <= SIZE_WORD;
            rd_uns_q  <= 1'b0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_ok_q   <= rd_ok_d;
            err_q     <= err_d;
            rd_word_q <= rd_word_d;
            rd_lo_q   <= rd_lo_d;
            rd_size_q <= rd_size_d;
            rd_uns_q  <= rd_uns_d;
        end
    end

    load_align_ext u_load_align_ext (
        .word          (rd_word_q),
        .lo            (rd_lo_q),
        .size          (rd_size_q),
        .load_unsigned (rd_uns_q),
        .result        (ext_word)
    );

    // Errored loads still pulse valid, but with zero data.
    assign rdata       = (rd_vld_q && rd_ok_q) ? ext_word : 32'h0;
    assign rdata_valid = rd_vld_q;
    assign access_err  = err_q;
    assign ready       = (state_q == ST_IDLE) && !rst;
    assign busy        = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_data_memory_sync.sv
// Directed bench for data_memory_sync (DEPTH=16, clear on reset).
module tb_data_memory_sync;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        load_unsigned;
    logic        ready;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        access_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SR = 2'b11;

    data_memory_sync #(
        .DEPTH          (16),
        .ADDR_W         (32),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .addr          (addr),
        .wdata         (wdata),
        .size          (size),
        .load_unsigned (load_unsigned),
        .ready         (ready),
        .rdata_valid   (rdata_valid),
        .rdata         (rdata),
        .access_err    (access_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request for one cycle; outputs checked afterwards belong to it.
    task automatic op(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] sz, input logic uns);
        mem_read      = rd;
        mem_write     = wr;
        addr          = a;
        wdata         = d;
        size          = sz;
        load_unsigned = uns;
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int n;
        logic seen_vld;
        logic seen_err;

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        addr = 32'h0; wdata = 32'h0; size = SW; load_unsigned = 1'b0;

        // 1. reset, clear sweep of exactly 16 cycles, all words zero
        tick(); tick();
        chk("rst_valid", {31'h0, rdata_valid}, 32'h0);
        chk("rst_err",   {31'h0, access_err},  32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_busy",  {31'h0, busy},  32'h1);
        rst = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk("clear_len",   n, 16);
        chk("clear_ready", {31'h0, ready}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b0, i * 4, 32'h0, SW, 1'b0);
            chk("clear_zero", {rdata_valid, rdata[30:0]}, {1'b1, 31'h0});
            chk("clear_top",  {31'h0, rdata[31]}, 32'h0);
        end

        // 2. word store then immediate load
        op(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, SW, 1'b0);
        chk("st_novalid", {31'h0, rdata_valid}, 32'h0);
        chk("st_noerr",   {31'h0, access_err},  32'h0);
        op(1'b1, 1'b0, 32'h8, 32'h0, SW, 1'b0);
        chk("lw_valid", {31'h0, rdata_valid}, 32'h1);
        chk("lw_data",  rdata, 32'hDEADBEEF);
        tick();
        chk("lw_pulse", {31'h0, rdata_valid}, 32'h0);
        chk("lw_idle_rdata", rdata, 32'h0);

        // 3. byte/half stores and extending loads
        op(1'b0, 1'b1, 32'h8, 32'h0, SW, 1'b0);
        op(1'b0, 1'b1, 32'h9, 32'hFFFFFF80, SB, 1'b0);
        op(1'b1, 1'b0, 32'h8, 32'h0, SW, 1'b0);
        chk("sb_word", rdata, 32'h00008000);
        op(1'b1, 1'b0, 32'h9, 32'h0, SB, 1'b0);
        chk("lb",  rdata, 32'hFFFFFF80);
        op(1'b1, 1'b0, 32'h9, 32'h0, SB, 1'b1);
        chk("lbu", rdata, 32'h00000080);
        op(1'b0, 1'b1, 32'hA, 32'h1234BEEF, SH, 1'b0);
        op(1'b1, 1'b0, 32'h8, 32'h0, SW, 1'b0);
        chk("sh_word", rdata, 32'hBEEF8000);
        op(1'b1, 1'b0, 32'hA, 32'h0, SH, 1'b0);
        chk("lh_hi",  rdata, 32'hFFFFBEEF);
        op(1'b1, 1'b0, 32'hA, 32'h0, SH, 1'b1);
        chk("lhu_hi", rdata, 32'h0000BEEF);
        op(1'b1, 1'b0, 32'h8, 32'h0, SH, 1'b0);
        chk("lh_lo",  rdata, 32'hFFFF8000);
        op(1'b1, 1'b0, 32'hB, 32'h0, SB, 1'b0);
        chk("lb_b3",  rdata, 32'hFFFFFFBE);

        // 4. misalignment, reserved size, read+write together
        op(1'b0, 1'b1, 32'h0, 32'h12345678, SW, 1'b0);
        op(1'b0, 1'b1, 32'h3, 32'h0000AAAA, SH, 1'b0);
        chk("sh_mis_err",   {31'h0, access_err},  32'h1);
        chk("sh_mis_valid", {31'h0, rdata_valid}, 32'h0);
        op(1'b1, 1'b0, 32'h0, 32'h0, SW, 1'b0);
        chk("sh_mis_unch", rdata, 32'h12345678);
        chk("err_pulse",   {31'h0, access_err}, 32'h0);
        op(1'b1, 1'b0, 32'h6, 32'h0, SW, 1'b0);
        chk("lw_mis_err",   {31'h0, access_err},  32'h1);
        chk("lw_mis_valid", {31'h0, rdata_valid}, 32'h1);
        chk("lw_mis_rdata", rdata, 32'h0);
        op(1'b1, 1'b0, 32'h0, 32'h0, SR, 1'b0);
        chk("rsvd_err",   {31'h0, access_err}, 32'h1);
        chk("rsvd_rdata", rdata, 32'h0);
        op(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, SW, 1'b0);
        chk("rw_err",   {31'h0, access_err},  32'h1);
        chk("rw_valid", {31'h0, rdata_valid}, 32'h0);
        op(1'b1, 1'b0, 32'h0, 32'h0, SW, 1'b0);
        chk("rw_unch", rdata, 32'h12345678);

        // 5. address wrap modulo DEPTH
        op(1'b0, 1'b1, 32'h40, 32'h00000011, SW, 1'b0);
        op(1'b1, 1'b0, 32'h0, 32'h0, SW, 1'b0);
        chk("wrap", rdata, 32'h00000011);

        // 6. reset mid-clear restarts the sweep; requests during busy dropped
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        n = 0;
        seen_vld = 1'b0;
        seen_err = 1'b0;
        addr = 32'h0; wdata = 32'hAAAAAAAA; size = SW;
        while (busy && n < 40) begin
            mem_read  = n[0];
            mem_write = ~n[0];
            n++;
            tick();
            seen_vld = seen_vld | rdata_valid;
            seen_err = seen_err | access_err;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk("restart_len", n, 16);
        chk("busy_no_valid", {31'h0, seen_vld}, 32'h0);
        chk("busy_no_err",   {31'h0, seen_err}, 32'h0);
        chk("restart_ready", {31'h0, ready}, 32'h1);
        op(1'b1, 1'b0, 32'h0, 32'h0, SW, 1'b0);
        chk("recleared_0", rdata, 32'h0);
        op(1'b1, 1'b0, 32'h8, 32'h0, SW, 1'b0);
        chk("recleared_8", {rdata_valid, rdata[30:0]}, {1'b1, 31'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
